// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the program RAM, resolves Jumps locally
// and hands every other instruction to execute. Optional macro: INSTR_FETCH_BRANCH_CNT_EN.
module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    input  logic [15:0] mem_dout,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        ex_idle,
    input  logic        zf,
    input  logic        cf,
    output logic [7:0]  pc,
    output logic [1:0]  fetch_state
`ifdef INSTR_FETCH_BRANCH_CNT_EN
    ,
    output logic [15:0] taken_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        JUMP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  pc_next;
    logic        ir_load;
    logic        jump_cond;
    logic        jump_taken;

    // Handshake: ir_valid rises only in ISSUE and stays high with ir stable until an
    // edge sees ir_ready=1; the word transfers exactly on that edge. Jumps never appear.
    assign ir_valid    = (state == ISSUE);
    assign mem_addr    = pc;
    assign mem_we      = 1'b0;
    assign fetch_state = state;

    // Condition select: ir[11:10] picks Z/NZ/C/NC; ir[12]=0 means unconditional.
    always_comb begin
        jump_cond = 1'b1;
        if (ir[12]) begin
            case (ir[11:10])
                2'b00:   jump_cond = zf;
                2'b01:   jump_cond = ~zf;
                2'b10:   jump_cond = cf;
                default: jump_cond = ~cf;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        jump_taken = 1'b0;
        case (state)
            FETCH: begin
                ir_load    = 1'b1;
                state_next = (mem_dout[15:13] == 3'b100) ? JUMP : ISSUE;
            end
            ISSUE: begin
                if (ir_ready) begin
                    pc_next    = pc + 8'd1;
                    state_next = FETCH;
                end
            end
            JUMP: begin
                // Flags are only trusted once execute has drained.
                if (ex_idle) begin
                    jump_taken = jump_cond;
                    pc_next    = jump_cond ? ir[7:0] : pc + 8'd1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= 8'h00;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ir_load) begin
                ir <= mem_dout;
            end
        end
    end

`ifdef INSTR_FETCH_BRANCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= 16'h0000;
        end else if (jump_taken && (taken_cnt != 16'hFFFF)) begin
            taken_cnt <= taken_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch with an instruction-level reference model.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_dout;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        ex_idle;
    logic        zf;
    logic        cf;
    logic [7:0]  pc;
    logic [1:0]  fetch_state;
`ifdef INSTR_FETCH_BRANCH_CNT_EN
    logic [15:0] taken_cnt;
`endif

    logic [15:0] ram [256];
    logic [23:0] exp_q [$];
    int          errors;
    int          checks;
    logic [7:0]  cur;
    logic [15:0] exp_cnt;

    assign mem_dout = ram[mem_addr];

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ex_idle    (ex_idle),
        .zf         (zf),
        .cf         (cf),
        .pc         (pc),
        .fetch_state(fetch_state)
`ifdef INSTR_FETCH_BRANCH_CNT_EN
        ,
        .taken_cnt  (taken_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the jump rule as stated for the ISA.
    function automatic logic is_taken(input logic [15:0] w, input logic z, input logic c);
        logic [3:0] opc;
        logic [1:0] sel;
        opc = w[15:12];
        sel = w[11:10];
        if (opc == 4'b1000) return 1'b1;
        if (sel == 2'd0) return z == 1'b1;
        if (sel == 2'd1) return z == 1'b0;
        if (sel == 2'd2) return c == 1'b1;
        return c == 1'b0;
    endfunction

    task automatic check_cnt(input string tag);
`ifdef INSTR_FETCH_BRANCH_CNT_EN
        check(tag, 32'(taken_cnt), 32'(exp_cnt));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // Execute one jump word at the current PC with the given flags, ex_idle held high.
    task automatic do_jump(input logic [15:0] w, input logic z, input logic c);
        logic [7:0] exp_pc;
        ram[cur] = w;
        zf = z;
        cf = c;
        ex_idle = 1'b1;
        tick();
        check("jump_ir", 32'(ir), 32'(w));
        check("jump_novalid", 32'(ir_valid), 32'd0);
        check("jump_pc_hold", 32'(pc), 32'(cur));
        tick();
        if (is_taken(w, z, c)) begin
            exp_pc = w[7:0];
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end else begin
            exp_pc = cur + 8'd1;
        end
        check("jump_pc", 32'(pc), 32'(exp_pc));
        check("jump_novalid2", 32'(ir_valid), 32'd0);
        check_cnt("jump_cnt");
        cur = exp_pc;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_cnt = 16'h0000;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[0] = 16'hA006;
        ram[1] = 16'h400A;
        ram[2] = 16'h9404;
        rst_n = 1'b0;
        ir_ready = 1'b0;
        ex_idle = 1'b0;
        zf = 1'b0;
        cf = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_state", 32'(fetch_state), 32'd0);
        check_cnt("rst_cnt");

        // linear fetch
        @(negedge clk);
        rst_n = 1'b1;
        ir_ready = 1'b1;
        ex_idle = 1'b1;
        tick();
        check("lin_ir0", 32'(ir), 32'hA006);
        check("lin_valid0", 32'(ir_valid), 32'd1);
        check("lin_pc0", 32'(pc), 32'd0);
        tick();
        check("lin_fetch_novalid", 32'(ir_valid), 32'd0);
        check("lin_pc1", 32'(pc), 32'd1);
        tick();
        check("lin_ir1", 32'(ir), 32'h400A);
        check("lin_valid1", 32'(ir_valid), 32'd1);
        tick();
        check("lin_pc2", 32'(pc), 32'd2);
        cur = 8'd2;

        // NZ jump taken with zf=0
        do_jump(16'h9404, 1'b0, 1'b0);
        check("nz_taken_pc", 32'(pc), 32'd4);

        // backpressure
        ram[4] = 16'h1234;
        ir_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(ir_valid), 32'd1);
            check("bp_ir", 32'(ir), 32'h1234);
            check("bp_pc", 32'(pc), 32'd4);
            tick();
        end
        ir_ready = 1'b1;
        tick();
        check("bp_release_pc", 32'(pc), 32'd5);

        // jump waits for execute
        ram[5] = 16'h8000;
        ex_idle = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wait_pc", 32'(pc), 32'd5);
            check("wait_novalid", 32'(ir_valid), 32'd0);
            tick();
        end
        check("wait_pc_end", 32'(pc), 32'd5);
        ex_idle = 1'b1;
        tick();
        check("wait_taken_pc", 32'(pc), 32'd0);
        exp_cnt = exp_cnt + 16'd1;
        check_cnt("wait_cnt");
        cur = 8'd0;

        // conditional variants
        do_jump(16'h9404, 1'b1, 1'b0);
        do_jump(16'h9020, 1'b1, 1'b0);
        do_jump(16'h9030, 1'b0, 1'b1);
        do_jump(16'h9840, 1'b1, 1'b0);
        do_jump(16'h9850, 1'b0, 1'b1);
        do_jump(16'h9C60, 1'b1, 1'b0);
        do_jump(16'h9C70, 1'b0, 1'b1);
        do_jump(16'h9380, 1'b1, 1'b1);
        do_jump(16'h8290, 1'b0, 1'b0);

        // wrap-around
        do_jump(16'h80FF, 1'b0, 1'b0);
        ram[255] = 16'h0000;
        ir_ready = 1'b1;
        tick();
        check("wrap_ir", 32'(ir), 32'h0000);
        check("wrap_valid", 32'(ir_valid), 32'd1);
        check("wrap_pc_ff", 32'(pc), 32'hFF);
        tick();
        check("wrap_pc", 32'(pc), 32'd0);
        cur = 8'd0;

        // asynchronous reset mid-ISSUE
        do_jump(16'h8007, 1'b0, 1'b0);
        ram[7] = 16'h5A5A;
        ir_ready = 1'b0;
        tick();
        check("mid_valid", 32'(ir_valid), 32'd1);
        check("mid_pc7", 32'(pc), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ir_valid), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_ir", 32'(ir), 32'd0);
        exp_cnt = 16'h0000;
        check_cnt("arst_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        ram[0] = 16'h2222;
        ir_ready = 1'b1;
        tick();
        check("restart_ir", 32'(ir), 32'h2222);
        check("restart_pc", 32'(pc), 32'd0);
        tick();
        check("restart_pc1", 32'(pc), 32'd1);
        cur = 8'd1;

        // randomized program against the instruction-level model
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'($urandom);
            if ($urandom_range(0, 9) < 3) ram[i][15:13] = 3'b100;
        end
        for (int step = 0; step < 300; step++) begin
            logic [15:0] w;
            int          k;
            w = ram[cur];
            k = $urandom_range(0, 3);
            ir_ready = 1'($urandom_range(0, 1));
            ex_idle = 1'($urandom_range(0, 1));
            zf = 1'($urandom_range(0, 1));
            cf = 1'($urandom_range(0, 1));
            tick();
            if (w[15:13] != 3'b100) begin
                exp_q.push_back({cur, w});
                ir_ready = 1'b0;
                for (int s = 0; s < k; s++) begin
                    check("rnd_stall_valid", 32'(ir_valid), 32'd1);
                    tick();
                end
                ir_ready = 1'b1;
                begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    check("rnd_issue_valid", 32'(ir_valid), 32'd1);
                    check("rnd_issue_pc", 32'(pc), 32'(e[23:16]));
                    check("rnd_issue_ir", 32'(ir), 32'(e[15:0]));
                end
                tick();
                cur = cur + 8'd1;
                check("rnd_next_pc", 32'(pc), 32'(cur));
            end else begin
                check("rnd_jump_novalid", 32'(ir_valid), 32'd0);
                for (int s = 0; s < k; s++) begin
                    ex_idle = 1'b0;
                    zf = 1'($urandom_range(0, 1));
                    cf = 1'($urandom_range(0, 1));
                    tick();
                    check("rnd_jump_hold", 32'(pc), 32'(cur));
                end
                ex_idle = 1'b1;
                zf = 1'($urandom_range(0, 1));
                cf = 1'($urandom_range(0, 1));
                if (is_taken(w, zf, cf)) begin
                    cur = w[7:0];
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end else begin
                    cur = cur + 8'd1;
                end
                tick();
                check("rnd_jump_pc", 32'(pc), 32'(cur));
                check_cnt("rnd_jump_cnt");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
